// File: rtl/panel_out_stage_if.sv
// -----------------------------------------------------------------------------
// panel_out_stage_if
// Pixel bus between an upstream video source and panel_out_stage.
//   iVS/iHS/iDE, iRDATA/iGDATA/iBDATA, iMODE : upstream syncs, pixel, mode request
//   oVS/oHS/oDE, oRDATA/oGDATA/oBDATA       : delayed syncs and formatted pixel
//   oMODE_ACT, oFRAME_CNT                    : latched mode and frame counter
// Modports: master = upstream/source side, slave = panel_out_stage side.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
interface panel_out_stage_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
);
  logic             iVS;
  logic             iHS;
  logic             iDE;
  logic [IN_W-1:0]  iRDATA;
  logic [IN_W-1:0]  iGDATA;
  logic [IN_W-1:0]  iBDATA;
  logic [2:0]       iMODE;
  logic             oVS;
  logic             oHS;
  logic             oDE;
  logic [OUT_W-1:0] oRDATA;
  logic [OUT_W-1:0] oGDATA;
  logic [OUT_W-1:0] oBDATA;
  logic [2:0]       oMODE_ACT;
  logic [7:0]       oFRAME_CNT;

  modport master (
    output iVS, iHS, iDE, iRDATA, iGDATA, iBDATA, iMODE,
    input  oVS, oHS, oDE, oRDATA, oGDATA, oBDATA, oMODE_ACT, oFRAME_CNT
  );

  modport slave (
    input  iVS, iHS, iDE, iRDATA, iGDATA, iBDATA, iMODE,
    output oVS, oHS, oDE, oRDATA, oGDATA, oBDATA, oMODE_ACT, oFRAME_CNT
  );
endinterface

// File: rtl/panel_out_stage.sv
// -----------------------------------------------------------------------------
// panel_out_stage
// Final pixel formatting stage in front of a panel: reduces IN_W-bit colour
// components to OUT_W bits (truncate, ordered dither, black, white, invert)
// and delays syncs and pixel by PIPE_DEPTH clocks.
// Ports:
//   iCLK_PLL : pixel clock
//   iRESET   : asynchronous, active-low reset
//   bus      : panel_out_stage_if.slave (syncs, pixel, mode in; formatted out)
// The requested mode is latched once per frame on the rising edge of iVS.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module panel_out_stage #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 6,
  parameter int PIPE_DEPTH = 2
) (
  input  logic               iCLK_PLL,
  input  logic               iRESET,
  panel_out_stage_if.slave   bus
);

  localparam int D  = IN_W - OUT_W;
  // Shift that brings the two bits just below the kept MSBs down to [1:0].
  localparam int DS = (D >= 2) ? (D - 2) : 0;
  localparam logic [OUT_W-1:0] ALL_ONES  = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] ALL_ZEROS = {OUT_W{1'b0}};

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_DITHER = 3'd1,
    MODE_BLACK  = 3'd2,
    MODE_WHITE  = 3'd3,
    MODE_INVERT = 3'd4
  } mode_e;

  logic        vs_prev_r;
  logic        de_prev_r;
  logic [10:0] x_r;
  logic [10:0] y_r;
  logic [7:0]  frame_r;
  logic [2:0]  mode_r;

  logic        frame_ev_s;
  logic [1:0]  thr_s;

  logic [PIPE_DEPTH-1:0] vs_pipe_r;
  logic [PIPE_DEPTH-1:0] hs_pipe_r;
  logic [PIPE_DEPTH-1:0] de_pipe_r;
  logic [OUT_W-1:0]      r_pipe_r [PIPE_DEPTH];
  logic [OUT_W-1:0]      g_pipe_r [PIPE_DEPTH];
  logic [OUT_W-1:0]      b_pipe_r [PIPE_DEPTH];

  logic [OUT_W-1:0] r_fmt_s;
  logic [OUT_W-1:0] g_fmt_s;
  logic [OUT_W-1:0] b_fmt_s;

  // Formats one component; the dither threshold is shared by R, G and B.
  function automatic logic [OUT_W-1:0] fmt_comp(
    input logic [IN_W-1:0] comp,
    input logic [2:0]      mode,
    input logic [1:0]      thr
  );
    logic [OUT_W-1:0] trunc;
    logic [1:0]       k;
    logic [OUT_W-1:0] res;
    trunc = comp[IN_W-1 -: OUT_W];
    if (D >= 2) begin
      k = 2'(comp >> DS);
    end else if (D == 1) begin
      k = {comp[0], 1'b0};
    end else begin
      // Nothing is discarded, so dither degenerates to pass.
      k = 2'd0;
    end
    case (mode)
      MODE_DITHER: begin
        if ((k > thr) && (trunc != ALL_ONES)) begin
          res = trunc + OUT_W'(1);
        end else begin
          res = trunc;
        end
      end
      MODE_BLACK:  res = ALL_ZEROS;
      MODE_WHITE:  res = ALL_ONES;
      MODE_INVERT: res = ~trunc;
      default:     res = trunc;
    endcase
    return res;
  endfunction

  assign frame_ev_s = bus.iVS & ~vs_prev_r;
  // Counter values before this edge belong to the pixel being sampled now.
  assign thr_s = {1'b0, x_r[0]} + {y_r[0], 1'b0} + frame_r[1:0];

  // Frame, position and mode tracking.
  always_ff @(posedge iCLK_PLL or negedge iRESET) begin
    if (!iRESET) begin
      vs_prev_r <= 1'b0;
      de_prev_r <= 1'b0;
      x_r       <= 11'd0;
      y_r       <= 11'd0;
      frame_r   <= 8'd0;
      mode_r    <= 3'd0;
    end else begin
      vs_prev_r <= bus.iVS;
      de_prev_r <= bus.iDE;
      x_r       <= bus.iDE ? (x_r + 11'd1) : 11'd0;
      if (frame_ev_s) begin
        y_r     <= 11'd0;
        frame_r <= frame_r + 8'd1;
        mode_r  <= bus.iMODE;
      end else if (de_prev_r && !bus.iDE) begin
        y_r     <= y_r + 11'd1;
      end else begin
        y_r     <= y_r;
      end
    end
  end

  // Stage-1 formatting; blanking cycles carry zero colour down the pipe.
  always_comb begin
    r_fmt_s = ALL_ZEROS;
    g_fmt_s = ALL_ZEROS;
    b_fmt_s = ALL_ZEROS;
    if (bus.iDE) begin
      r_fmt_s = fmt_comp(bus.iRDATA, mode_r, thr_s);
      g_fmt_s = fmt_comp(bus.iGDATA, mode_r, thr_s);
      b_fmt_s = fmt_comp(bus.iBDATA, mode_r, thr_s);
    end else begin
      r_fmt_s = ALL_ZEROS;
      g_fmt_s = ALL_ZEROS;
      b_fmt_s = ALL_ZEROS;
    end
  end

  // Delay pipeline: stage 0 captures formatted data, later stages just shift.
  always_ff @(posedge iCLK_PLL or negedge iRESET) begin
    if (!iRESET) begin
      vs_pipe_r <= {PIPE_DEPTH{1'b0}};
      hs_pipe_r <= {PIPE_DEPTH{1'b0}};
      de_pipe_r <= {PIPE_DEPTH{1'b0}};
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe_r[i] <= ALL_ZEROS;
        g_pipe_r[i] <= ALL_ZEROS;
        b_pipe_r[i] <= ALL_ZEROS;
      end
    end else begin
      vs_pipe_r[0] <= bus.iVS;
      hs_pipe_r[0] <= bus.iHS;
      de_pipe_r[0] <= bus.iDE;
      r_pipe_r[0]  <= r_fmt_s;
      g_pipe_r[0]  <= g_fmt_s;
      b_pipe_r[0]  <= b_fmt_s;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vs_pipe_r[i] <= vs_pipe_r[i-1];
        hs_pipe_r[i] <= hs_pipe_r[i-1];
        de_pipe_r[i] <= de_pipe_r[i-1];
        r_pipe_r[i]  <= r_pipe_r[i-1];
        g_pipe_r[i]  <= g_pipe_r[i-1];
        b_pipe_r[i]  <= b_pipe_r[i-1];
      end
    end
  end

  assign bus.oVS        = vs_pipe_r[PIPE_DEPTH-1];
  assign bus.oHS        = hs_pipe_r[PIPE_DEPTH-1];
  assign bus.oDE        = de_pipe_r[PIPE_DEPTH-1];
  assign bus.oRDATA     = r_pipe_r[PIPE_DEPTH-1];
  assign bus.oGDATA     = g_pipe_r[PIPE_DEPTH-1];
  assign bus.oBDATA     = b_pipe_r[PIPE_DEPTH-1];
  assign bus.oMODE_ACT  = mode_r;
  assign bus.oFRAME_CNT = frame_r;

endmodule
